rx_ipv4_demux: RTL and testbench

Parametrised IPv4 receive parser that succeeds the fixed-format IPv4 receiver. It consumes the byte stream the Ethernet MAC receiver emits for EtherType 0x0800 and validates the header: version, IHL, options, header checksum, destination address, fragmentation and length. Accepted payload is demultiplexed to one of `N_PROTO` upper-layer receivers (UDP, TCP, ICMP, …), Ethernet padding is stripped, and every dropped packet is reported with an error code.

---
 rtl/rx_ipv4_demux_if.sv | 27 ++
 rtl/rx_ipv4_demux.sv | 252 +++++++++++++++++++++++++
 tb/tb_rx_ipv4_demux.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_ipv4_demux_if.sv
// Byte stream into the IPv4 parser and demultiplexed payload out of it.
interface rx_ipv4_demux_if #(
  parameter int OCT     = 8,
  parameter int N_PROTO = 2
);
  logic               rx_payload_ipv4;
  logic [OCT-1:0]     rx_payload;
  logic [OCT-1:0]     rx_data;
  logic [N_PROTO-1:0] rx_data_valid;
  logic               rx_data_last;

  modport master (
    output rx_payload_ipv4,
    output rx_payload,
    input  rx_data,
    input  rx_data_valid,
    input  rx_data_last
  );

  modport slave (
    input  rx_payload_ipv4,
    input  rx_payload,
    output rx_data,
    output rx_data_valid,
    output rx_data_last
  );
endinterface

// File: rtl/rx_ipv4_demux.sv
// IPv4 header validation and per-protocol payload demux with
// padding strip and drop-reason reporting.
module rx_ipv4_demux #(
  parameter int OCT = 8,
  parameter int N_PROTO = 2,
  parameter logic [N_PROTO*OCT-1:0] PROTO_LIST = {8'h06, 8'h11},
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        RX_CLK,
  input  logic        rst,
  input  logic [31:0] ip_addr,
  rx_ipv4_demux_if.slave bus,
  output logic        rx_irq_ipv4,
  output logic        rx_err,
  output logic [2:0]  rx_err_code,
  output logic [31:0] rx_src_ip,
  output logic [2:0]  rx_proto_idx,
  output logic [15:0] rx_payload_len
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [7:0]         hcnt_q, hcnt_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic [3:0]         ihl_q, ihl_d;
  logic [15:0]        tlen_q, tlen_d;
  logic               frag_q, frag_d;
  logic [7:0]         proto_q, proto_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [OCT-1:0]     hi_q, hi_d;
  logic [15:0]        csum_q, csum_d;
  logic [N_PROTO-1:0] sel_q, sel_d;

  logic [OCT-1:0]     data_q, data_d;
  logic [N_PROTO-1:0] dval_q, dval_d;
  logic               last_q, last_d;
  logic               irq_q, irq_d;
  logic               err_q, err_d;
  logic [2:0]         code_q, code_d;
  logic [31:0]        sip_q, sip_d;
  logic [2:0]         pidx_q, pidx_d;
  logic [15:0]        plen_q, plen_d;

  logic           v;
  logic [OCT-1:0] b;
  logic [16:0]    csum_sum;
  logic [15:0]    csum_add;
  logic [7:0]     hdr_len;
  logic [15:0]    plen;
  logic [31:0]    dst_now;
  logic           dst_ok;
  logic           hit;
  logic [2:0]     idx;

  assign v = bus.rx_payload_ipv4;
  assign b = bus.rx_payload;

  // ones-complement add with end-around carry folded every word
  assign csum_sum = {1'b0, csum_q} + {1'b0, hi_q, b};
  assign csum_add = csum_sum[15:0] + {15'd0, csum_sum[16]};
  assign hdr_len  = {2'b00, ihl_q, 2'b00};
  assign plen     = tlen_q - {8'h00, hdr_len};
  assign dst_now  = (hcnt_q == 8'd19) ? {dst_q[23:0], b} : dst_q;
  assign dst_ok   = (dst_now == ip_addr) ||
                    (ACCEPT_BCAST && dst_now == 32'hFFFF_FFFF);

  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = N_PROTO - 1; i >= 0; i--) begin
      if (PROTO_LIST[i*OCT +: OCT] == proto_q) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    ihl_d   = ihl_q;
    tlen_d  = tlen_q;
    frag_d  = frag_q;
    proto_d = proto_q;
    src_d   = src_q;
    dst_d   = dst_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    sel_d   = sel_q;
    data_d  = data_q;
    dval_d  = '0;
    last_d  = 1'b0;
    irq_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    sip_d   = sip_q;
    pidx_d  = pidx_q;
    plen_d  = plen_q;

    unique case (state_q)
      S_WAIT: begin
        if (!v) begin
          state_d = S_HDR;
          hcnt_d  = 8'd0;
        end
      end
      S_HDR: begin
        if (v) begin
          hcnt_d = hcnt_q + 8'd1;
          if (!hcnt_q[0]) hi_d = b;
          else            csum_d = csum_add;
          if (hcnt_q >= 8'd12 && hcnt_q < 8'd16)
            src_d = {src_q[23:0], b};
          if (hcnt_q >= 8'd16 && hcnt_q < 8'd20)
            dst_d = {dst_q[23:0], b};
          case (hcnt_q)
            8'd0: begin
              ihl_d  = b[3:0];
              csum_d = 16'd0;
              frag_d = 1'b0;
              if (b[7:4] != 4'd4 || b[3:0] < 4'd5) begin
                err_d   = 1'b1;
                code_d  = 3'd1;
                state_d = S_DISC;
                hcnt_d  = 8'd0;
              end
            end
            8'd2: tlen_d[15:8] = b;
            8'd3: tlen_d[7:0]  = b;
            8'd6: frag_d = b[5] | (|b[4:0]);
            8'd7: frag_d = frag_q | (|b);
            8'd9: proto_d = b;
            default: ;
          endcase
          if (hcnt_q != 8'd0 && hcnt_q == hdr_len - 8'd1) begin
            hcnt_d  = 8'd0;
            state_d = S_DISC;
            err_d   = 1'b1;
            if (csum_add != 16'hFFFF)           code_d = 3'd2;
            else if (!dst_ok)                   code_d = 3'd3;
            else if (frag_q)                    code_d = 3'd4;
            else if (!hit)                      code_d = 3'd5;
            else if (tlen_q < {8'h00, hdr_len}) code_d = 3'd6;
            else begin
              err_d  = 1'b0;
              sip_d  = src_q;
              pidx_d = idx;
              plen_d = plen;
              sel_d  = N_PROTO'(1) << idx;
              pcnt_d = {8'h00, hdr_len};
              if (plen == 16'd0) irq_d = 1'b1;
              else               state_d = S_PAY;
            end
          end
        end else if (hcnt_q != 8'd0) begin
          err_d  = 1'b1;
          code_d = 3'd7;
          hcnt_d = 8'd0;
        end
      end
      S_PAY: begin
        if (v) begin
          data_d = b;
          dval_d = sel_q;
          pcnt_d = pcnt_q + 16'd1;
          if (pcnt_q == tlen_q - 16'd1) begin
            last_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = S_DISC;
          end
        end else begin
          err_d   = 1'b1;
          code_d  = 3'd7;
          state_d = S_HDR;
          hcnt_d  = 8'd0;
        end
      end
      S_DISC: begin
        if (!v) begin
          state_d = S_HDR;
          hcnt_d  = 8'd0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q <= S_WAIT;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      ihl_q   <= '0;
      tlen_q  <= '0;
      frag_q  <= 1'b0;
      proto_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      dval_q  <= '0;
      last_q  <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      sip_q   <= '0;
      pidx_q  <= '0;
      plen_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      ihl_q   <= ihl_d;
      tlen_q  <= tlen_d;
      frag_q  <= frag_d;
      proto_q <= proto_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      last_q  <= last_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      code_q  <= code_d;
      sip_q   <= sip_d;
      pidx_q  <= pidx_d;
      plen_q  <= plen_d;
    end
  end

  assign bus.rx_data       = data_q;
  assign bus.rx_data_valid = dval_q;
  assign bus.rx_data_last  = last_q;
  assign rx_irq_ipv4       = irq_q;
  assign rx_err            = err_q;
  assign rx_err_code       = code_q;
  assign rx_src_ip         = sip_q;
  assign rx_proto_idx      = pidx_q;
  assign rx_payload_len    = plen_q;

endmodule

// File: tb/tb_rx_ipv4_demux.sv
// Directed frames against rx_ipv4_demux with hand-derived
// expectations for accept paths, drop codes and reset.
module tb_rx_ipv4_demux;

  logic        RX_CLK = 1'b0;
  logic        rst;
  logic [31:0] ip_addr;
  logic        rx_irq_ipv4;
  logic        rx_err;
  logic [2:0]  rx_err_code;
  logic [31:0] rx_src_ip;
  logic [2:0]  rx_proto_idx;
  logic [15:0] rx_payload_len;

  rx_ipv4_demux_if #(.OCT(8), .N_PROTO(2)) bus();

  rx_ipv4_demux dut (
    .RX_CLK(RX_CLK),
    .rst(rst),
    .ip_addr(ip_addr),
    .bus(bus),
    .rx_irq_ipv4(rx_irq_ipv4),
    .rx_err(rx_err),
    .rx_err_code(rx_err_code),
    .rx_src_ip(rx_src_ip),
    .rx_proto_idx(rx_proto_idx),
    .rx_payload_len(rx_payload_len)
  );

  always #5 RX_CLK = ~RX_CLK;

  localparam logic [31:0] LOCAL = 32'hC0A8_010A;
  localparam logic [31:0] SRC   = 32'hC0A8_0101;

  logic [7:0] frame[$];
  int total = 0;
  int bad = 0;
  int beats, last_cnt, irq_cnt, irq_last, err_cnt;
  int err_idx, irq_idx;
  logic [1:0] vmask;
  logic [7:0] first_byte, last_byte;
  logic [2:0] code_seen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    beats = 0; last_cnt = 0; irq_cnt = 0; irq_last = 0;
    err_cnt = 0; err_idx = -1; irq_idx = -1;
    vmask = '0; first_byte = '0; last_byte = '0; code_seen = '0;
  endtask

  task automatic tick(input logic v, input logic [7:0] b,
                      input int idx, input logic r);
    bus.rx_payload_ipv4 = v;
    bus.rx_payload = b;
    rst = r;
    @(posedge RX_CLK);
    #1;
    if (|bus.rx_data_valid) begin
      if (beats == 0) first_byte = bus.rx_data;
      beats++;
      vmask |= bus.rx_data_valid;
    end
    if (bus.rx_data_last) begin
      last_cnt++;
      last_byte = bus.rx_data;
    end
    if (rx_irq_ipv4) begin
      irq_cnt++;
      irq_idx = idx;
      if (bus.rx_data_last) irq_last++;
    end
    if (rx_err) begin
      err_cnt++;
      err_idx = idx;
      code_seen = rx_err_code;
    end
  endtask

  task automatic send(input int n, input int rlo, input int rhi);
    clr();
    for (int i = 0; i < n; i++)
      tick(1'b1, frame[i], i, (i >= rlo && i < rhi));
    tick(1'b0, 8'h00, n, 1'b0);
  endtask

  task automatic mk(input logic [3:0] ver, input logic [3:0] ihl,
                    input logic [15:0] tlen, input logic mf,
                    input logic [7:0] proto, input logic [31:0] dst);
    logic [7:0] h[0:59];
    logic [16:0] s;
    logic [15:0] ck;
    for (int i = 0; i < 60; i++) h[i] = 8'hA0 + 8'(i);
    h[0] = {ver, ihl}; h[1] = 8'h00;
    h[2] = tlen[15:8]; h[3] = tlen[7:0];
    h[4] = 8'h12; h[5] = 8'h34;
    h[6] = {2'b00, mf, 5'b0}; h[7] = 8'h00;
    h[8] = 8'h40; h[9] = proto;
    h[10] = 8'h00; h[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      h[12+i] = SRC[31-8*i -: 8];
      h[16+i] = dst[31-8*i -: 8];
    end
    s = '0;
    for (int i = 0; i < 2 * int'(ihl); i++) begin
      s = {1'b0, s[15:0]} + {1'b0, h[2*i], h[2*i+1]};
      s = {1'b0, s[15:0]} + {16'd0, s[16]};
    end
    ck = ~s[15:0];
    h[10] = ck[15:8]; h[11] = ck[7:0];
    frame.delete();
    for (int i = 0; i < 4 * int'(ihl); i++) frame.push_back(h[i]);
  endtask

  task automatic pay(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) frame.push_back(start + 8'(i));
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) frame.push_back(8'h00);
  endtask

  task automatic good_udp();
    mk(4'd4, 4'd5, 16'd28, 1'b0, 8'h11, LOCAL);
    pay(8, 8'h01);
    pad(18);
  endtask

  initial begin
    ip_addr = LOCAL;
    bus.rx_payload_ipv4 = 1'b0;
    bus.rx_payload = 8'h00;
    rst = 1'b1;
    clr();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, -1, 1'b1);
    chk("rst_valid", 32'(bus.rx_data_valid), 0);
    chk("rst_flags", {bus.rx_data_last, rx_irq_ipv4, rx_err}, 0);
    chk("rst_code", 32'(rx_err_code), 0);
    chk("rst_src", rx_src_ip, 0);
    chk("rst_len", 32'(rx_payload_len), 0);
    chk("rst_data", 32'(bus.rx_data), 0);
    tick(1'b0, 8'h00, -1, 1'b0);

    good_udp();
    send(frame.size(), -1, -1);
    chk("udp_beats", beats, 8);
    chk("udp_mask", 32'(vmask), 1);
    chk("udp_first", 32'(first_byte), 32'h01);
    chk("udp_last_cnt", last_cnt, 1);
    chk("udp_last_byte", 32'(last_byte), 32'h08);
    chk("udp_irq", irq_cnt, 1);
    chk("udp_irq_last", irq_last, 1);
    chk("udp_irq_idx", irq_idx, 27);
    chk("udp_err", err_cnt, 0);
    chk("udp_len", 32'(rx_payload_len), 8);
    chk("udp_idx", 32'(rx_proto_idx), 0);
    chk("udp_src", rx_src_ip, SRC);

    mk(4'd4, 4'd7, 16'd32, 1'b0, 8'h06, LOCAL);
    pay(4, 8'hA1);
    send(frame.size(), -1, -1);
    chk("tcp_beats", beats, 4);
    chk("tcp_mask", 32'(vmask), 2);
    chk("tcp_last_byte", 32'(last_byte), 32'hA4);
    chk("tcp_irq", irq_cnt, 1);
    chk("tcp_err", err_cnt, 0);
    chk("tcp_len", 32'(rx_payload_len), 4);
    chk("tcp_idx", 32'(rx_proto_idx), 1);

    good_udp();
    frame[11] = frame[11] ^ 8'h01;
    send(frame.size(), -1, -1);
    chk("ck_err", err_cnt, 1);
    chk("ck_code", 32'(code_seen), 2);
    chk("ck_idx", err_idx, 19);
    chk("ck_beats", beats, 0);
    chk("ck_irq", irq_cnt, 0);
    good_udp();
    send(frame.size(), -1, -1);
    chk("b2b_irq", irq_cnt, 1);
    chk("b2b_beats", beats, 8);
    chk("b2b_err", err_cnt, 0);

    mk(4'd4, 4'd5, 16'd28, 1'b0, 8'h11, 32'h0A00_0001);
    pay(8, 8'h01);
    send(frame.size(), -1, -1);
    chk("dst_code", 32'(code_seen), 3);
    chk("dst_err", err_cnt, 1);
    chk("dst_beats", beats, 0);

    mk(4'd4, 4'd5, 16'd28, 1'b1, 8'h11, LOCAL);
    pay(8, 8'h01);
    send(frame.size(), -1, -1);
    chk("mf_code", 32'(code_seen), 4);
    chk("mf_idx", err_idx, 19);

    mk(4'd4, 4'd5, 16'd28, 1'b0, 8'h01, LOCAL);
    pay(8, 8'h01);
    send(frame.size(), -1, -1);
    chk("proto_code", 32'(code_seen), 5);
    chk("proto_beats", beats, 0);

    mk(4'd4, 4'd5, 16'd28, 1'b0, 8'h11, 32'hFFFF_FFFF);
    pay(8, 8'h11);
    send(frame.size(), -1, -1);
    chk("bc_irq", irq_cnt, 1);
    chk("bc_err", err_cnt, 0);
    chk("bc_first", 32'(first_byte), 32'h11);
    chk("code_held", 32'(rx_err_code), 5);

    mk(4'd4, 4'd5, 16'd16, 1'b0, 8'h11, LOCAL);
    pad(6);
    send(frame.size(), -1, -1);
    chk("short_code", 32'(code_seen), 6);
    chk("short_idx", err_idx, 19);

    mk(4'd4, 4'd5, 16'd20, 1'b0, 8'h06, LOCAL);
    pad(6);
    send(frame.size(), -1, -1);
    chk("zero_irq", irq_cnt, 1);
    chk("zero_irq_idx", irq_idx, 19);
    chk("zero_beats", beats, 0);
    chk("zero_len", 32'(rx_payload_len), 0);
    chk("zero_pidx", 32'(rx_proto_idx), 1);

    mk(4'd6, 4'd5, 16'd28, 1'b0, 8'h11, LOCAL);
    pay(8, 8'h01);
    send(frame.size(), -1, -1);
    chk("ver_err", err_cnt, 1);
    chk("ver_code", 32'(code_seen), 1);
    chk("ver_idx", err_idx, 0);
    chk("ver_beats", beats, 0);

    good_udp();
    send(23, -1, -1);
    chk("trunc_beats", beats, 3);
    chk("trunc_last", last_cnt, 0);
    chk("trunc_irq", irq_cnt, 0);
    chk("trunc_err", err_cnt, 1);
    chk("trunc_code", 32'(code_seen), 7);
    chk("trunc_idx", err_idx, 23);

    good_udp();
    send(frame.size(), 10, 12);
    chk("mrst_beats", beats, 0);
    chk("mrst_irq", irq_cnt, 0);
    chk("mrst_err", err_cnt, 0);
    chk("mrst_len", 32'(rx_payload_len), 0);
    good_udp();
    send(frame.size(), -1, -1);
    chk("post_irq", irq_cnt, 1);
    chk("post_beats", beats, 8);
    chk("post_len", 32'(rx_payload_len), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
